mmio_timer_uart_tx: RTL and testbench



---
 rtl/mmio_timer_uart_tx.sv | 152 +++++++++++++++
 tb/tb_mmio_timer_uart_tx.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer_uart_tx.sv
// Data-bus responder with a free-running machine timer (compare + irq) and a console TX FIFO.
// Optional macro MMIO_PRESCALER_EN adds a 16-bit timer prescaler register at offset 0x14.
module mmio_timer_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rhit,
    output logic              irq,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [5:0] R_CTRL     = 6'h00;
    localparam logic [5:0] R_STATUS   = 6'h01;
    localparam logic [5:0] R_MTIME    = 6'h02;
    localparam logic [5:0] R_MTIMECMP = 6'h03;
    localparam logic [5:0] R_TXDATA   = 6'h04;
`ifdef MMIO_PRESCALER_EN
    localparam logic [5:0] R_PRESCALE = 6'h05;
`endif

    logic              ctrl_ten, ctrl_ien, pend, ovf;
    logic [DATA_W-1:0] mtime, mtimecmp, status;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              w_win, full, empty, pop, push_req, push, pend_set, tick;
    logic [5:0]        wsel;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{waddr[1:0], raddr[1:0]};

    assign w_win    = we && (waddr[31:8] == BASE_ADDR[31:8]);
    assign wsel     = waddr[7:2];
    assign rhit     = re && (raddr[31:8] == BASE_ADDR[31:8]);

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
    assign pop      = tx_valid && tx_ready;
    assign push_req = w_win && (wsel == R_TXDATA);
    // A pop in the same edge frees the slot, so a full FIFO can still accept.
    assign push     = push_req && (!full || pop);
    assign pend_set = ctrl_ten && (mtime == mtimecmp);

`ifdef MMIO_PRESCALER_EN
    logic [15:0] prescale, pcnt;
    assign tick = ctrl_ten && (pcnt == prescale);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale <= '0;
            pcnt     <= '0;
        end else if (w_win && (wsel == R_PRESCALE)) begin
            prescale <= wdata[15:0];
            pcnt     <= '0;
        end else if (ctrl_ten) begin
            pcnt <= (pcnt == prescale) ? 16'h0 : pcnt + 16'h1;
        end
    end
`else
    assign tick = ctrl_ten;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_ten <= 1'b0;
            ctrl_ien <= 1'b0;
            pend     <= 1'b0;
            ovf      <= 1'b0;
            mtime    <= '0;
            mtimecmp <= '1;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            irq      <= 1'b0;
        end else begin
            if (w_win && (wsel == R_CTRL)) begin
                ctrl_ten <= wdata[0];
                ctrl_ien <= wdata[1];
            end
            if (w_win && (wsel == R_MTIME))
                mtime <= wdata;
            else if (tick)
                mtime <= mtime + DATA_W'(1);
            if (w_win && (wsel == R_MTIMECMP))
                mtimecmp <= wdata;
            // Hardware set takes priority over software clear.
            if (pend_set)
                pend <= 1'b1;
            else if (w_win && (wsel == R_STATUS) && wdata[0])
                pend <= 1'b0;
            if (push_req && !push)
                ovf <= 1'b1;
            else if (w_win && (wsel == R_STATUS) && wdata[3])
                ovf <= 1'b0;
            irq <= pend & ctrl_ien;
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= wdata[7:0];
    end

    always_comb begin
        status        = '0;
        status[0]     = pend;
        status[1]     = full;
        status[2]     = empty;
        status[3]     = ovf;
        status[8 +: CNT_W] = count;
    end

    always_comb begin
        rdata = '0;
        if (rhit) begin
            case (raddr[7:2])
                R_CTRL:     rdata = DATA_W'({ctrl_ien, ctrl_ten});
                R_STATUS:   rdata = status;
                R_MTIME:    rdata = mtime;
                R_MTIMECMP: rdata = mtimecmp;
`ifdef MMIO_PRESCALER_EN
                R_PRESCALE: rdata = DATA_W'(prescale);
`endif
                default:    rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_timer_uart_tx.sv
// Self-checking bench for mmio_timer_uart_tx: directed timer scenarios plus randomized FIFO traffic vs a queue model.
module tb_mmio_timer_uart_tx;
    localparam logic [31:0] BASE       = 32'h1000_0000;
    localparam logic [31:0] A_CTRL     = BASE + 32'h00;
    localparam logic [31:0] A_STATUS   = BASE + 32'h04;
    localparam logic [31:0] A_MTIME    = BASE + 32'h08;
    localparam logic [31:0] A_MTIMECMP = BASE + 32'h0C;
    localparam logic [31:0] A_TXDATA   = BASE + 32'h10;
    localparam logic [31:0] A_PRESCALE = BASE + 32'h14;
    localparam int          DEPTH      = 8;

    logic        clk = 1'b0;
    logic        rst, we, re, tx_ready, rhit, irq, tx_valid;
    logic [31:0] waddr, wdata, raddr, rdata;
    logic [7:0]  tx_data;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  q[$];
    bit          ovf_m;

    mmio_timer_uart_tx #(
        .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .rhit(rhit), .irq(irq),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_status(int cnt, bit ovf_b, bit pend_b);
        logic [31:0] s;
        s       = '0;
        s[14:8] = 7'(cnt);
        s[3]    = ovf_b;
        s[2]    = (cnt == 0);
        s[1]    = (cnt == DEPTH);
        s[0]    = pend_b;
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
        re = 1'b1; raddr = a;
        #1;
        d = rdata; h = rhit;
        re = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] offs [8] = '{A_CTRL, A_STATUS, A_MTIME, A_MTIMECMP, A_TXDATA, A_PRESCALE, BASE + 32'h18, 32'h2000_0000};
        logic [31:0] expv [8] = '{32'h0, 32'h4, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        logic        exph [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] d;
        logic        h;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({irq, tx_valid, tx_data, rdata, rhit} !== 43'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: irq=%b tx_valid=%b tx_data=%h rdata=%h rhit=%b, required all zero", irq, tx_valid, tx_data, rdata, rhit);
        end
        for (int i = 0; i < 8; i++) begin
            bus_read(offs[i], d, h);
            n_cmp++;
            if (d !== expv[i] || h !== exph[i]) begin
                n_bad++;
                $display("FAIL reset_read[%h]: got %h hit=%b, required %h hit=%b", offs[i], d, h, expv[i], exph[i]);
            end
        end
        step();
    endtask

    task automatic test_timer_irq();
        logic [31:0] d, s;
        logic        h;
        bus_write(A_MTIMECMP, 32'd10);
        bus_write(A_MTIME, 32'd0);
        bus_write(A_CTRL, 32'd3);
        for (int k = 0; k <= 14; k++) begin
            bus_read(A_MTIME, d, h);
            bus_read(A_STATUS, s, h);
            n_cmp++;
            if (d !== 32'(k) || s !== exp_status(0, 1'b0, k >= 11) || irq !== (k >= 12)) begin
                n_bad++;
                $display("FAIL timer_cycle%0d: mtime=%0d status=%h irq=%b, required mtime=%0d status=%h irq=%b",
                         k, d, s, irq, k, exp_status(0, 1'b0, k >= 11), k >= 12);
            end
            step();
        end
        bus_write(A_STATUS, 32'd1);
        bus_read(A_STATUS, s, h);
        n_cmp++;
        if (s[0] !== 1'b0 || irq !== 1'b1) begin
            n_bad++;
            $display("FAIL pend_w1c: pend=%b irq=%b, required pend=0 irq=1", s[0], irq);
        end
        step();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_drop: irq=%b, required 0", irq);
        end
        bus_write(A_CTRL, 32'd0);
    endtask

    task automatic test_wrap();
        logic [31:0] d, s, e;
        logic        h;
        bus_write(A_STATUS, 32'h9);
        bus_write(A_MTIMECMP, 32'd5);
        bus_write(A_MTIME, 32'hFFFF_FFFE);
        bus_write(A_CTRL, 32'd1);
        for (int k = 0; k <= 6; k++) begin
            e = 32'hFFFF_FFFE + 32'(k);
            bus_read(A_MTIME, d, h);
            bus_read(A_STATUS, s, h);
            n_cmp++;
            if (d !== e || s[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL wrap_cycle%0d: mtime=%h pend=%b, required mtime=%h pend=0", k, d, s[0], e);
            end
            step();
        end
        bus_write(A_CTRL, 32'd0);
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] s;
        logic        h;
        bus_write(A_STATUS, 32'h9);
        tx_ready = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus_write(A_TXDATA, 32'h41 + 32'(i));
            if (q.size() < DEPTH) q.push_back(8'h41 + 8'(i));
            else ovf_m = 1'b1;
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_data !== q[0]) begin
                n_bad++;
                $display("FAIL ovf_head%0d: valid=%b data=%h, required valid=1 data=%h", i, tx_valid, tx_data, q[0]);
            end
        end
        bus_read(A_STATUS, s, h);
        n_cmp++;
        if (s !== exp_status(q.size(), ovf_m, 1'b0)) begin
            n_bad++;
            $display("FAIL ovf_status: got %h, required %h", s, exp_status(q.size(), ovf_m, 1'b0));
        end
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_data !== q[0]) begin
                n_bad++;
                $display("FAIL ovf_drain%0d: valid=%b data=%h, required valid=1 data=%h", i, tx_valid, tx_data, q[0]);
            end
            void'(q.pop_front());
            step();
        end
        tx_ready = 1'b0;
        bus_read(A_STATUS, s, h);
        n_cmp++;
        if (s !== exp_status(0, 1'b1, 1'b0) || tx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_empty: status=%h valid=%b, required status=%h valid=0", s, tx_valid, exp_status(0, 1'b1, 1'b0));
        end
        bus_write(A_STATUS, 32'h8);
        bus_read(A_STATUS, s, h);
        n_cmp++;
        if (s !== 32'h4) begin
            n_bad++;
            $display("FAIL ovf_clear: status=%h, required 00000004", s);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] s;
        logic        h;
        logic [7:0]  b;
        tx_ready = 1'b0;
        q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            bus_write(A_TXDATA, {$urandom} & 32'hFFFF_FF00 | 32'(b));
            q.push_back(b);
        end
        tx_ready = 1'b1;
        bus_write(A_TXDATA, 32'h55);
        tx_ready = 1'b0;
        void'(q.pop_front());
        q.push_back(8'h55);
        bus_read(A_STATUS, s, h);
        n_cmp++;
        if (s !== exp_status(DEPTH, 1'b0, 1'b0)) begin
            n_bad++;
            $display("FAIL full_pushpop_status: got %h, required %h", s, exp_status(DEPTH, 1'b0, 1'b0));
        end
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_data !== q[0]) begin
                n_bad++;
                $display("FAIL full_pushpop_drain%0d: valid=%b data=%h, required valid=1 data=%h", i, tx_valid, tx_data, q[0]);
            end
            void'(q.pop_front());
            step();
        end
        tx_ready = 1'b0;
        n_cmp++;
        if (tx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL full_pushpop_empty: valid=%b, required 0", tx_valid);
        end
    endtask

    task automatic test_random_fifo();
        bit         push_r, rdy, popped;
        logic [7:0] b;
        q.delete();
        ovf_m = 1'b0;
        for (int c = 0; c < 300; c++) begin
            push_r = ($urandom_range(0, 2) != 0);
            rdy    = 1'($urandom_range(0, 1));
            b      = 8'($urandom);
            we = push_r; waddr = A_TXDATA; wdata = ({$urandom} & 32'hFFFF_FF00) | 32'(b);
            tx_ready = rdy;
            re = 1'b1; raddr = A_STATUS;
            #1;
            n_cmp++;
            if (tx_valid !== (q.size() != 0) || (q.size() != 0 && tx_data !== q[0])
                || rdata !== exp_status(q.size(), ovf_m, 1'b0)) begin
                n_bad++;
                $display("FAIL random_cycle%0d: valid=%b data=%h status=%h, required valid=%b data=%h status=%h",
                         c, tx_valid, tx_data, rdata, q.size() != 0, (q.size() != 0) ? q[0] : 8'h00,
                         exp_status(q.size(), ovf_m, 1'b0));
            end
            re = 1'b0;
            popped = (q.size() != 0) && rdy;
            if (popped) void'(q.pop_front());
            if (push_r) begin
                if (q.size() < DEPTH) q.push_back(b);
                else ovf_m = 1'b1;
            end
            step();
        end
        we = 1'b0;
        tx_ready = 1'b1;
        repeat (DEPTH) step();
        tx_ready = 1'b0;
        q.delete();
        bus_write(A_STATUS, 32'h8);
    endtask

    task automatic test_same_cycle();
        logic [31:0] d;
        logic        h;
        bus_write(A_MTIME, 32'h0000_1234);
        we = 1'b1; waddr = A_MTIME; wdata = 32'h0000_ABCD;
        re = 1'b1; raddr = A_MTIME;
        #1;
        n_cmp++;
        if (rdata !== 32'h0000_1234) begin
            n_bad++;
            $display("FAIL same_cycle_pre: rdata=%h, required 00001234", rdata);
        end
        re = 1'b0;
        step();
        we = 1'b0;
        bus_read(A_MTIME, d, h);
        n_cmp++;
        if (d !== 32'h0000_ABCD) begin
            n_bad++;
            $display("FAIL same_cycle_post: rdata=%h, required 0000abcd", d);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [31:0] s, c;
        logic        h;
        tx_ready = 1'b0;
        bus_write(A_CTRL, 32'd3);
        for (int i = 0; i < DEPTH + 1; i++) bus_write(A_TXDATA, 32'($urandom));
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_read(A_STATUS, s, h);
        bus_read(A_CTRL, c, h);
        n_cmp++;
        if (s !== 32'h4 || c !== 32'h0 || tx_valid !== 1'b0 || tx_data !== 8'h00 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: status=%h ctrl=%h valid=%b data=%h irq=%b, required 00000004/0/0/00/0",
                     s, c, tx_valid, tx_data, irq);
        end
        step();
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        logic        h;
`ifdef MMIO_PRESCALER_EN
        bus_write(A_PRESCALE, 32'd3);
        bus_write(A_MTIME, 32'd0);
        bus_write(A_CTRL, 32'd1);
        repeat (39) step();
        bus_write(A_CTRL, 32'd0);
        bus_read(A_MTIME, d, h);
        n_cmp++;
        if (d !== 32'd10) begin
            n_bad++;
            $display("FAIL prescale_mtime: got %0d, required 10", d);
        end
        bus_read(A_PRESCALE, d, h);
        n_cmp++;
        if (d !== 32'd3 || h !== 1'b1) begin
            n_bad++;
            $display("FAIL prescale_read: got %h hit=%b, required 00000003 hit=1", d, h);
        end
`else
        bus_write(A_PRESCALE, 32'd3);
        bus_read(A_PRESCALE, d, h);
        n_cmp++;
        if (d !== 32'd0 || h !== 1'b1) begin
            n_bad++;
            $display("FAIL prescale_absent: got %h hit=%b, required 00000000 hit=1", d, h);
        end
`endif
        step();
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; re = 1'b0; tx_ready = 1'b0;
        waddr = '0; wdata = '0; raddr = '0;
        test_reset();
        test_timer_irq();
        test_wrap();
        test_fifo_overflow();
        test_full_push_pop();
        test_random_fifo();
        test_same_cycle();
        test_reset_mid();
        test_prescale();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
